// File: rtl/ddr3_ui_if.sv
// ddr3_ui_if: app_* user-interface bundle between the frame-buffer master and the DDR3 UI.
// The master drives commands and write data; the slave returns readiness, read data and calibration status.
interface ddr3_ui_if;
  logic [27:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic         app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         init_calib_complete;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, init_calib_complete
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, init_calib_complete
  );
endinterface

// File: rtl/ddr3_ui_responder.sv
// ddr3_ui_responder: block-RAM stand-in for the DDR3 controller user interface (app_* handshake).
// Define DDR3_UI_BACKPRESSURE_EN to add LFSR-driven random stalls on app_rdy / app_wdf_rdy.
module ddr3_ui_responder #(
  parameter int MEM_AW      = 10,
  parameter int RD_LATENCY  = 4,
  parameter int INIT_CYCLES = 16,
  parameter int WDF_DEPTH   = 4
) (
  input  logic     ui_clk,
  input  logic     ui_clk_sync_rst,
  ddr3_ui_if.slave ui
);
  localparam int DATA_W = 128;
  localparam int MASK_W = DATA_W / 8;
  localparam int WDQ_W  = DATA_W + MASK_W;
  localparam int QPW    = (WDF_DEPTH > 1) ? $clog2(WDF_DEPTH) : 1;
  localparam int QCW    = $clog2(WDF_DEPTH + 1);
  localparam int ICW    = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES + 1) : 1;

  logic [ICW-1:0]        r_init_cnt;
  logic                  r_calib;
  logic [MEM_AW-1:0]     r_wcq [WDF_DEPTH];
  logic [QPW-1:0]        r_wcq_wp, r_wcq_rp;
  logic [QCW-1:0]        r_wcq_cnt;
  logic [WDQ_W-1:0]      r_wdq [WDF_DEPTH];
  logic [QPW-1:0]        r_wdq_wp, r_wdq_rp;
  logic [QCW-1:0]        r_wdq_cnt;
  logic [DATA_W-1:0]     r_mem [2**MEM_AW];
  logic [RD_LATENCY-1:0] r_vld_p;
  logic [DATA_W-1:0]     r_dat_p [RD_LATENCY];
  logic                  r_rd_vld;
  logic [DATA_W-1:0]     r_rd_dat;

  logic              w_bp_ok, w_cmd_ok, w_cmd_acc, w_wr_acc, w_rd_acc, w_dat_acc, w_commit;
  logic              w_wcq_full, w_wcq_empty, w_wdq_full, w_wdq_empty;
  logic [MEM_AW-1:0] w_idx, w_cmt_idx;
  logic [WDQ_W-1:0]  w_cmt_ent;
  logic              w_unused_ok;

  function automatic logic [QPW-1:0] ptr_inc(input logic [QPW-1:0] p);
    return (p == QPW'(WDF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef DDR3_UI_BACKPRESSURE_EN
  logic [15:0] r_lfsr;
  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) r_lfsr <= 16'hACE1;
    else                 r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end
  assign w_bp_ok = (r_lfsr[1:0] != 2'b00);
`else
  assign w_bp_ok = 1'b1;
`endif

  assign w_idx       = ui.app_addr[MEM_AW+2:3];
  assign w_wcq_full  = (r_wcq_cnt == QCW'(WDF_DEPTH));
  assign w_wcq_empty = (r_wcq_cnt == '0);
  assign w_wdq_full  = (r_wdq_cnt == QCW'(WDF_DEPTH));
  assign w_wdq_empty = (r_wdq_cnt == '0);

  // Reads wait for every queued write command so a read never overtakes a write.
  always_comb begin
    w_cmd_ok = 1'b1;
    case (ui.app_cmd)
      3'b000:  w_cmd_ok = !w_wcq_full;
      3'b001:  w_cmd_ok = w_wcq_empty;
      default: w_cmd_ok = 1'b1;
    endcase
  end

  assign ui.app_rdy             = r_calib && w_bp_ok && w_cmd_ok;
  assign ui.app_wdf_rdy         = r_calib && w_bp_ok && !w_wdq_full;
  assign ui.app_rd_data         = r_rd_dat;
  assign ui.app_rd_data_valid   = r_rd_vld;
  assign ui.init_calib_complete = r_calib;

  assign w_cmd_acc = ui.app_en && ui.app_rdy;
  assign w_wr_acc  = w_cmd_acc && (ui.app_cmd == 3'b000);
  assign w_rd_acc  = w_cmd_acc && (ui.app_cmd == 3'b001);
  assign w_dat_acc = ui.app_wdf_wren && ui.app_wdf_rdy;
  assign w_commit  = !w_wcq_empty && !w_wdq_empty;
  assign w_cmt_idx = r_wcq[r_wcq_rp];
  assign w_cmt_ent = r_wdq[r_wdq_rp];

  // Burst-end carries no information at 4:1 and the out-of-range address bits wrap.
  assign w_unused_ok = ^{ui.app_wdf_end, ui.app_addr[27:MEM_AW+3], ui.app_addr[2:0]};

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      r_init_cnt <= '0;
      r_calib    <= 1'b0;
      r_wcq_wp   <= '0;
      r_wcq_rp   <= '0;
      r_wcq_cnt  <= '0;
      r_wdq_wp   <= '0;
      r_wdq_rp   <= '0;
      r_wdq_cnt  <= '0;
      r_vld_p    <= '0;
    end else begin
      if (!r_calib) begin
        r_init_cnt <= r_init_cnt + 1'b1;
        if (r_init_cnt == ICW'(INIT_CYCLES - 1)) r_calib <= 1'b1;
      end
      if (w_wr_acc)  r_wcq_wp <= ptr_inc(r_wcq_wp);
      if (w_dat_acc) r_wdq_wp <= ptr_inc(r_wdq_wp);
      if (w_commit) begin
        r_wcq_rp <= ptr_inc(r_wcq_rp);
        r_wdq_rp <= ptr_inc(r_wdq_rp);
      end
      r_wcq_cnt <= r_wcq_cnt + QCW'(w_wr_acc) - QCW'(w_commit);
      r_wdq_cnt <= r_wdq_cnt + QCW'(w_dat_acc) - QCW'(w_commit);
      r_vld_p[0] <= w_rd_acc;
      for (int s = 1; s < RD_LATENCY; s++) r_vld_p[s] <= r_vld_p[s-1];
    end
  end

  // Stage p0: synchronous RAM read; stages p1..p(RD_LATENCY-1) just delay it.
  always_ff @(posedge ui_clk) begin
    if (w_wr_acc)  r_wcq[r_wcq_wp] <= w_idx;
    if (w_dat_acc) r_wdq[r_wdq_wp] <= {ui.app_wdf_mask, ui.app_wdf_data};
    if (w_commit) begin
      for (int b = 0; b < MASK_W; b++)
        if (!w_cmt_ent[DATA_W + b]) r_mem[w_cmt_idx][b*8 +: 8] <= w_cmt_ent[b*8 +: 8];
    end
    if (w_rd_acc) r_dat_p[0] <= r_mem[w_idx];
    for (int s = 1; s < RD_LATENCY; s++) r_dat_p[s] <= r_dat_p[s-1];
  end

  // Output stage: data holds its last value between read strobes.
  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      r_rd_vld <= 1'b0;
      r_rd_dat <= '0;
    end else begin
      r_rd_vld <= r_vld_p[RD_LATENCY-1];
      if (r_vld_p[RD_LATENCY-1]) r_rd_dat <= r_dat_p[RD_LATENCY-1];
    end
  end
endmodule

// File: tb/tb_ddr3_ui_responder.sv
// tb_ddr3_ui_responder: scoreboard bench for ddr3_ui_responder with a queue-based memory model.
module tb_ddr3_ui_responder;
  localparam int AW   = 10;
  localparam int LAT  = 4;
  localparam int INIT = 16;
  localparam int DEP  = 4;

  typedef struct {
    logic [127:0] d;
    int           c;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ddr3_ui_if ui ();

  ddr3_ui_responder #(
    .MEM_AW(AW), .RD_LATENCY(LAT), .INIT_CYCLES(INIT), .WDF_DEPTH(DEP)
  ) dut (
    .ui_clk(clk),
    .ui_clk_sync_rst(rst),
    .ui(ui)
  );

  int           vectors = 0;
  int           miscompares = 0;
  int           cyc = 0;
  int           run = 0;
  int           max_run = 0;
  logic [127:0] mdl [2**AW];
  logic [AW-1:0] mcq [$];
  logic [143:0] mdq [$];
  exp_t         sbq [$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic wait_fail(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: handshake wait expired at cycle %0d", nm, cyc);
  endtask

  // Reference model: accepted commands and data beats pair up in order; reads see all paired writes.
  always @(posedge clk) begin : observer
    logic [AW-1:0] ix;
    logic [143:0]  dm;
    exp_t          e;
    cyc = cyc + 1;
    if (rst) begin
      mcq.delete();
      mdq.delete();
      sbq.delete();
    end else begin
      if (ui.app_wdf_wren && ui.app_wdf_rdy) mdq.push_back({ui.app_wdf_mask, ui.app_wdf_data});
      if (ui.app_en && ui.app_rdy) begin
        ix = ui.app_addr[AW+2:3];
        if (ui.app_cmd == 3'b000) mcq.push_back(ix);
        else if (ui.app_cmd == 3'b001) begin
          chk("rd_order", 128'(mcq.size()), 128'd0);
          e.d = mdl[ix];
          e.c = cyc + LAT;
          sbq.push_back(e);
        end
      end
      while (mcq.size() > 0 && mdq.size() > 0) begin
        ix = mcq.pop_front();
        dm = mdq.pop_front();
        for (int b = 0; b < 16; b++)
          if (!dm[128 + b]) mdl[ix][b*8 +: 8] = dm[b*8 +: 8];
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (ui.app_rd_data_valid) begin
        run++;
        if (run > max_run) max_run = run;
        if (sbq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rd_unexpected: valid with data %h, no read outstanding", ui.app_rd_data);
        end else begin
          e = sbq.pop_front();
          chk("rd_data", ui.app_rd_data, e.d);
          chk("rd_lat", 128'(cyc), 128'(e.c));
        end
      end else begin
        run = 0;
      end
    end
  end

  task automatic send_cmd(input logic [2:0] c, input logic [27:0] a);
    int t = 0;
    ui.app_cmd = c;
    ui.app_addr = a;
    ui.app_en = 1'b1;
    forever begin
      #1;
      if (ui.app_rdy) begin
        @(negedge clk);
        break;
      end
      @(negedge clk);
      t++;
      if (t > 500) begin
        wait_fail("cmd_wait");
        break;
      end
    end
    ui.app_en = 1'b0;
  endtask

  task automatic send_data(input logic [127:0] d, input logic [15:0] m);
    int t = 0;
    ui.app_wdf_data = d;
    ui.app_wdf_mask = m;
    ui.app_wdf_wren = 1'b1;
    ui.app_wdf_end = 1'b1;
    forever begin
      #1;
      if (ui.app_wdf_rdy) begin
        @(negedge clk);
        break;
      end
      @(negedge clk);
      t++;
      if (t > 500) begin
        wait_fail("data_wait");
        break;
      end
    end
    ui.app_wdf_wren = 1'b0;
    ui.app_wdf_end = 1'b0;
  endtask

  task automatic do_write(input logic [27:0] a, input logic [127:0] d, input logic [15:0] m);
    int t = 0;
    bit cd = 1'b0;
    bit dd = 1'b0;
    bit ca, da;
    ui.app_cmd = 3'b000;
    ui.app_addr = a;
    ui.app_en = 1'b1;
    ui.app_wdf_data = d;
    ui.app_wdf_mask = m;
    ui.app_wdf_wren = 1'b1;
    ui.app_wdf_end = 1'b1;
    while (!(cd && dd)) begin
      #1;
      ca = ui.app_en && ui.app_rdy;
      da = ui.app_wdf_wren && ui.app_wdf_rdy;
      @(negedge clk);
      if (ca) begin cd = 1'b1; ui.app_en = 1'b0; end
      if (da) begin dd = 1'b1; ui.app_wdf_wren = 1'b0; ui.app_wdf_end = 1'b0; end
      t++;
      if (t > 500) begin
        wait_fail("write_wait");
        ui.app_en = 1'b0;
        ui.app_wdf_wren = 1'b0;
        break;
      end
    end
  endtask

  task automatic run_random(input int n);
    logic [27:0]  a;
    logic [127:0] d;
    logic [15:0]  m;
    int           op;
    for (int i = 0; i < n; i++) begin
      a = 28'($urandom);
      d = {$urandom, $urandom, $urandom, $urandom};
      m = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'h0000;
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2: do_write(a, d, m);
        3:       begin send_data(d, m); send_cmd(3'b000, a); end
        4:       begin send_cmd(3'b000, a); send_data(d, m); end
        5, 6, 7: send_cmd(3'b001, a);
        8:       send_cmd(3'($urandom_range(2, 7)), a);
        default: repeat ($urandom_range(1, 3)) @(negedge clk);
      endcase
    end
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    ui.app_addr = '0;
    ui.app_cmd = 3'b000;
    ui.app_en = 1'b0;
    ui.app_wdf_data = '0;
    ui.app_wdf_mask = '0;
    ui.app_wdf_wren = 1'b0;
    ui.app_wdf_end = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rdy", 128'(ui.app_rdy), 128'd0);
    chk("rst_wdf_rdy", 128'(ui.app_wdf_rdy), 128'd0);
    chk("rst_valid", 128'(ui.app_rd_data_valid), 128'd0);
    chk("rst_rd_data", ui.app_rd_data, 128'd0);
    chk("rst_calib", 128'(ui.init_calib_complete), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= INIT + 1; k++) begin
      @(negedge clk);
      #1;
      chk("calib", 128'(ui.init_calib_complete), 128'(k >= INIT));
      chk("calib_rdy", 128'(ui.app_rdy), 128'(k >= INIT));
      chk("calib_wdf_rdy", 128'(ui.app_wdf_rdy), 128'(k >= INIT));
    end
    @(negedge clk);

    // Plain write then read of address 8
    do_write(28'h8, 128'h0123456789ABCDEF0123456789ABCDEF, 16'h0000);
    send_cmd(3'b001, 28'h8);
    repeat (LAT + 2) @(negedge clk);
    chk("wr_rd_8", ui.app_rd_data, 128'h0123456789ABCDEF0123456789ABCDEF);

    // Byte-masked merge
    do_write(28'h20, {16{8'hAA}}, 16'h0000);
    do_write(28'h20, {16{8'h55}}, 16'h00FF);
    send_cmd(3'b001, 28'h20);
    repeat (LAT + 2) @(negedge clk);
    chk("mask_merge", ui.app_rd_data, {{8{8'h55}}, {8{8'hAA}}});

    // Write command without data blocks a following read until commit
    send_cmd(3'b000, 28'h40);
    ui.app_cmd = 3'b001;
    ui.app_addr = 28'h40;
    ui.app_en = 1'b1;
    repeat (5) begin
      #1 chk("rd_blocked", 128'(ui.app_rdy), 128'd0);
      @(negedge clk);
    end
    ui.app_wdf_data = 128'hFEEDFACE_CAFEBABE_DEADBEEF_00C0FFEE;
    ui.app_wdf_mask = 16'h0000;
    ui.app_wdf_wren = 1'b1;
    #1 chk("late_data_rdy", 128'(ui.app_wdf_rdy), 128'd1);
    @(negedge clk);
    ui.app_wdf_wren = 1'b0;
    #1 chk("rd_blocked_commit", 128'(ui.app_rdy), 128'd0);
    @(negedge clk);
    #1 chk("rd_after_commit", 128'(ui.app_rdy), 128'd1);
    @(negedge clk);
    ui.app_en = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    chk("late_data_rd", ui.app_rd_data, 128'hFEEDFACE_CAFEBABE_DEADBEEF_00C0FFEE);

    // Data queue fills with no commands, then drains
    for (int i = 0; i < DEP; i++) send_data(128'(32'hB000 + i), 16'h0000);
    #1 chk("wdf_full", 128'(ui.app_wdf_rdy), 128'd0);
    for (int i = 0; i < DEP; i++) send_cmd(3'b000, 28'(28'h100 + i * 8));
    #1 chk("wdf_drain", 128'(ui.app_wdf_rdy), 128'd1);
    for (int i = 0; i < DEP; i++) send_cmd(3'b001, 28'(28'h100 + i * 8));
    repeat (LAT + 4) @(negedge clk);

    // Preload every word with its index, then 80 back-to-back reads
    for (int i = 0; i < 2**AW; i++) do_write(28'(i * 8), 128'(i), 16'h0000);
    repeat (4) @(negedge clk);
    #1;
    run = 0;
    max_run = 0;
    for (int i = 0; i < 80; i++) send_cmd(3'b001, 28'(i * 8));
    repeat (LAT + 4) @(negedge clk);
    chk("rd_run", 128'(max_run), 128'd80);

    run_random(400);
    repeat (LAT + 4) @(negedge clk);

    // Reset with an orphan data beat and reads in flight
    send_data(128'h0BAD_0BAD, 16'h0000);
    ui.app_cmd = 3'b001;
    ui.app_addr = 28'h8;
    ui.app_en = 1'b1;
    @(negedge clk);
    ui.app_addr = 28'h10;
    @(negedge clk);
    ui.app_en = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("mid_rst_valid", 128'(ui.app_rd_data_valid), 128'd0);
    chk("mid_rst_calib", 128'(ui.init_calib_complete), 128'd0);
    chk("mid_rst_rdy", 128'(ui.app_rdy), 128'd0);
    chk("mid_rst_rd_data", ui.app_rd_data, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (INIT - 1) @(negedge clk);
    #1 chk("recal_early", 128'(ui.init_calib_complete), 128'd0);
    @(negedge clk);
    #1 chk("recal", 128'(ui.init_calib_complete), 128'd1);
    @(negedge clk);
    do_write(28'h200, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 16'h0000);
    send_cmd(3'b001, 28'h200);
    for (int i = 0; i < 24; i++) send_cmd(3'b001, 28'(i * 8));
    run_random(60);
    repeat (LAT + 6) @(negedge clk);
    chk("sb_drained", 128'(sbq.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
